// File: rtl/rv_pkg.sv
// Shared RV32I fetch-path definitions: word width, the canonical NOP and the
// response entry that travels through the instruction-memory responder.
package rv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

    typedef struct packed {
        logic            err;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic addr_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction
endpackage

// File: rtl/rv_sync_fifo.sv
// Small synchronous FIFO with first-word fall-through head; reset and flush
// only rewind the pointers, the slot storage is left as is.
module rv_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 3,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);
    logic [WIDTH-1:0] slots [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_idx;
    logic             do_push;
    logic             do_pop;
    logic             wr_en;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // A flush drops the contents but still takes a same-cycle push into slot 0.
    assign wr_en   = flush ? push : do_push;
    assign wr_idx  = flush ? '0 : wr_ptr;
    assign head    = slots[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= push ? PW'(1) : '0;
            count  <= push ? CW'(1) : '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en && !reset) slots[wr_idx] <= data;
    end
endmodule

// File: rtl/rv_imem_responder.sv
// Instruction-memory responder for the RV32I fetch stage: fixed-latency word
// fetch with in-order responses, backpressure, branch flush and a load port.
module rv_imem_responder
    import rv_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1,
    localparam int AW         = $clog2(DEPTH_WORDS),
    localparam int FIFO_DEPTH = LATENCY + 2,
    localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_instr,
    output logic            rsp_err,
    input  logic            flush,
    input  logic            ld_en,
    input  logic [AW-1:0]   ld_addr,
    input  logic [XLEN-1:0] ld_data,
    output logic            busy
);
    logic [XLEN-1:0] mem [DEPTH_WORDS];
    fetch_entry_t    in_e;
    fetch_entry_t    out_e;
    fetch_entry_t    head_e;
    logic            acc;
    logic            out_v;
    logic            bad_addr;
    logic            fifo_empty;
    logic            fifo_full;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     occupancy;

    // Handshake: a request moves on a clock edge where req_valid && req_ready,
    // a response moves where rsp_valid && rsp_ready; an offered response holds
    // steady until taken, and req_ready looks only at registered occupancy so
    // accepted work always has a FIFO slot waiting for it.
    assign occupancy = {1'b0, inflight} + {1'b0, fifo_count};
    assign req_ready = !reset && !fifo_full && (occupancy < (CW + 1)'(FIFO_DEPTH));
    assign acc       = req_valid && req_ready;

    always_ff @(posedge clock) begin
        if (ld_en) mem[ld_addr] <= ld_data;
    end

    // The read happens in the accept cycle, so a same-cycle load is not seen.
    assign bad_addr = addr_misaligned(req_addr) ||
                      (req_addr[XLEN-1:2] >= (XLEN - 2)'(DEPTH_WORDS));

    always_comb begin
        in_e.err   = bad_addr;
        in_e.instr = bad_addr ? RV_NOP : mem[req_addr[AW+1:2]];
    end

    generate
        if (LATENCY == 1) begin : g_direct
            assign out_v    = acc;
            assign out_e    = in_e;
            assign inflight = '0;
        end else begin : g_pipe
            logic         pv [1:LATENCY-1];
            fetch_entry_t pe [1:LATENCY-1];

            always_ff @(posedge clock) begin
                if (reset) begin
                    for (int i = 1; i < LATENCY; i++) pv[i] <= 1'b0;
                end else begin
                    // A request accepted in the flush cycle belongs to the new path.
                    pv[1] <= acc;
                    for (int i = 2; i < LATENCY; i++) pv[i] <= flush ? 1'b0 : pv[i-1];
                end
            end

            always_ff @(posedge clock) begin
                pe[1] <= in_e;
                for (int i = 2; i < LATENCY; i++) pe[i] <= pe[i-1];
            end

            always_comb begin
                inflight = '0;
                for (int i = 1; i < LATENCY; i++) inflight = inflight + CW'(pv[i]);
            end

            assign out_v = pv[LATENCY-1] && !flush;
            assign out_e = pe[LATENCY-1];
        end
    endgenerate

    rv_sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (out_v),
        .data  (out_e),
        .pop   (rsp_valid && rsp_ready),
        .flush (flush),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (head_e)
    );

    assign rsp_valid = !reset && !fifo_empty;
    assign rsp_instr = rsp_valid ? head_e.instr : '0;
    assign rsp_err   = rsp_valid && head_e.err;
    assign busy      = !reset && (occupancy != '0);
endmodule
